uart_mmio: RTL and testbench

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio_if.sv | 25 ++
 rtl/uart_mmio.sv | 133 +++++++++++++
 tb/tb_uart_mmio.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_if.sv
// CPU load/store port and the byte streams to and from the on-chip UART,
// bundled for the memory-mapped UART bridge.
interface uart_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output addr, wdata, we, re, tx_ready, rx_data, rx_valid,
    input  rdata, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  addr, wdata, we, re, tx_ready, rx_data, rx_valid,
    output rdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped UART bridge: status / RX-data / TX-data registers in front of
// one RX and one TX byte FIFO, with a sticky flag for bytes dropped on TX overflow.
module uart_mmio #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset_b,
  uart_mmio_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [7:0]  tx_mem_d [FIFO_DEPTH];
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [7:0]  rx_mem_d [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic        tx_drop_q, tx_drop_d;
  logic [31:0] rdata_q, rdata_d;

  logic sel_status_s, sel_rx_s, sel_tx_s;
  logic tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic drop_set_s, drop_clr_s;
  logic unused_s;

  assign unused_s = ^bus.wdata[31:8];

  // Address decode, FIFO flags and the push/pop/drop events of this edge.
  always_comb begin
    sel_status_s = (bus.addr == BASE_ADDR);
    sel_rx_s     = (bus.addr == (BASE_ADDR + 32'd4));
    sel_tx_s     = (bus.addr == (BASE_ADDR + 32'd8));
    tx_empty_s   = (tx_wp_q == tx_rp_q);
    rx_empty_s   = (rx_wp_q == rx_rp_q);
    tx_full_s    = (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]) && (tx_wp_q[AW] != tx_rp_q[AW]);
    rx_full_s    = (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]) && (rx_wp_q[AW] != rx_rp_q[AW]);
    // Fullness is judged on pre-edge state, so a same-edge UART pop cannot rescue a write.
    tx_push_s    = bus.we && sel_tx_s && !tx_full_s;
    drop_set_s   = bus.we && sel_tx_s && tx_full_s;
    drop_clr_s   = bus.we && sel_status_s && bus.wdata[2];
    tx_pop_s     = !tx_empty_s && bus.tx_ready;
    rx_push_s    = bus.rx_valid && !rx_full_s;
    rx_pop_s     = bus.re && sel_rx_s && !rx_empty_s;
  end

  // Next-state for both FIFOs, the sticky drop flag and the load result.
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;

    if (tx_push_s) begin
      tx_mem_d[tx_wp_q[AW-1:0]] = bus.wdata[7:0];
      tx_wp_d = tx_wp_q + PTR_ONE;
    end else begin
      tx_wp_d = tx_wp_q;
    end

    if (tx_pop_s) begin
      tx_rp_d = tx_rp_q + PTR_ONE;
    end else begin
      tx_rp_d = tx_rp_q;
    end

    if (rx_push_s) begin
      rx_mem_d[rx_wp_q[AW-1:0]] = bus.rx_data;
      rx_wp_d = rx_wp_q + PTR_ONE;
    end else begin
      rx_wp_d = rx_wp_q;
    end

    if (rx_pop_s) begin
      rx_rp_d = rx_rp_q + PTR_ONE;
    end else begin
      rx_rp_d = rx_rp_q;
    end

    // A drop on this edge wins over a software clear on the same edge.
    if (drop_set_s) begin
      tx_drop_d = 1'b1;
    end else if (drop_clr_s) begin
      tx_drop_d = 1'b0;
    end else begin
      tx_drop_d = tx_drop_q;
    end

    if (!bus.re) begin
      rdata_d = rdata_q;
    end else if (sel_status_s) begin
      rdata_d = {29'd0, tx_drop_q, !rx_empty_s, !tx_full_s};
    end else if (sel_rx_s && !rx_empty_s) begin
      rdata_d = {24'd0, rx_mem_q[rx_rp_q[AW-1:0]]};
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State registers; reset empties both FIFOs and discards buffered bytes.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_mem_q  <= '{default: 8'd0};
      rx_mem_q  <= '{default: 8'd0};
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_drop_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      tx_mem_q  <= tx_mem_d;
      rx_mem_q  <= rx_mem_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_drop_q <= tx_drop_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.tx_valid = !tx_empty_s;
  assign bus.tx_data  = tx_mem_q[tx_rp_q[AW-1:0]];
  assign bus.rx_ready = !rx_full_s;

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized bench for uart_mmio: a queue-based reference model predicts load
// results and transmitted bytes; a separate monitor checks them as they appear.
module tb_uart_mmio;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  uart_mmio_if bus();

  uart_mmio #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_b(reset_b), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  m_tx [$];
  logic [7:0]  m_rx [$];
  bit          m_drop = 1'b0;
  logic [31:0] sb_rd [$];
  logic [7:0]  sb_tx [$];
  bit          rst_seen = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: check flags against the model, drive inputs, advance the model.
  task automatic cyc(input logic re_i, input logic we_i, input logic [31:0] a,
                     input logic [31:0] wd, input logic txr, input logic rxv,
                     input logic [7:0] rxd);
    logic [31:0] exp;
    bit txf, rxf;
    @(posedge clk);
    #1;
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_tx.size() != 0));
    if (m_tx.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(m_tx[0]));
    chk("rx_ready", 32'(bus.rx_ready), 32'(m_rx.size() < DEPTH));
    bus.re = re_i; bus.we = we_i; bus.addr = a; bus.wdata = wd;
    bus.tx_ready = txr; bus.rx_valid = rxv; bus.rx_data = rxd;
    txf = (m_tx.size() == DEPTH);
    rxf = (m_rx.size() == DEPTH);
    if (re_i) begin
      exp = 32'd0;
      if (a == BASE) exp = {29'd0, m_drop, m_rx.size() != 0, !txf};
      else if (a == BASE + 32'd4 && m_rx.size() != 0) exp = {24'd0, m_rx.pop_front()};
      sb_rd.push_back(exp);
    end
    if (txr && m_tx.size() != 0) void'(m_tx.pop_front());
    if (we_i && a == BASE + 32'd8) begin
      if (txf) m_drop = 1'b1;
      else begin
        m_tx.push_back(wd[7:0]);
        sb_tx.push_back(wd[7:0]);
      end
    end else if (we_i && a == BASE && wd[2]) begin
      m_drop = 1'b0;
    end
    if (rxv && !rxf) m_rx.push_back(rxd);
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, txr, 1'b0, 8'd0);
  endtask
  task automatic rd(input logic [31:0] a);
    cyc(1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, 8'd0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 1'b0, 8'd0);
  endtask
  task automatic rxin(input logic [7:0] b);
    cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, b);
  endtask

  // Reset pulse placed between clock edges, with immediate output checks.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    bus.re = 1'b0; bus.we = 1'b0; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0;
    reset_b = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("rst_rdata", bus.rdata, 32'd0);
    m_tx.delete(); m_rx.delete(); sb_tx.delete(); sb_rd.delete();
    m_drop = 1'b0;
    rst_seen = 1'b1;
    #1;
    reset_b = 1'b1;
  endtask

  // Monitor: transmitted bytes at mid-cycle, load results just after the edge.
  initial begin
    logic        cap_re;
    logic [31:0] last_rd;
    last_rd = 32'd0;
    forever begin
      @(negedge clk);
      if (reset_b && bus.tx_valid && bus.tx_ready) begin
        if (sb_tx.size() == 0) chk("tx_unexpected", 32'(bus.tx_data), 32'hxxxx_xxxx);
        else chk("tx_byte", 32'(bus.tx_data), 32'(sb_tx.pop_front()));
      end
      cap_re = bus.re;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        last_rd = 32'd0;
        rst_seen = 1'b0;
      end
      if (cap_re) begin
        if (sb_rd.size() == 0) chk("rd_unexpected", bus.rdata, 32'hxxxx_xxxx);
        else begin
          last_rd = sb_rd.pop_front();
          chk("rdata", bus.rdata, last_rd);
        end
      end else begin
        chk("rdata_hold", bus.rdata, last_rd);
      end
    end
  end

  initial begin
    logic [31:0] alist [6];
    logic [31:0] r;
    bus.re = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'd0;
    #23;
    chk("por_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("por_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("por_rdata", bus.rdata, 32'd0);
    reset_b = 1'b1;

    // Echo
    rxin(8'h7A);
    rd(BASE);
    rd(BASE + 32'd4);
    wr(BASE + 32'd8, 32'h1234_567A);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // RX fill and overflow
    for (int i = 1; i <= 5; i++) rxin(8'(i));
    for (int i = 0; i < 5; i++) rd(BASE + 32'd4);

    // TX overflow, sticky drop, clear, drain
    for (int i = 0; i < 5; i++) wr(BASE + 32'd8, 32'hA0 + 32'(i));
    rd(BASE);
    wr(BASE, 32'd4);
    rd(BASE);
    idle(6, 1'b1);

    // Simultaneous push/pop on each FIFO
    for (int i = 0; i < 3; i++) wr(BASE + 32'd8, 32'hB0 + 32'(i));
    cyc(1'b0, 1'b1, BASE + 32'd8, 32'hB3, 1'b1, 1'b0, 8'd0);
    idle(1, 1'b0);
    idle(4, 1'b1);
    rxin(8'hC0); rxin(8'hC1);
    cyc(1'b1, 1'b0, BASE + 32'd4, 32'd0, 1'b0, 1'b1, 8'hC2);
    rd(BASE + 32'd4); rd(BASE + 32'd4); rd(BASE + 32'd4);

    // Reset with both FIFOs half full
    wr(BASE + 32'd8, 32'hD0); wr(BASE + 32'd8, 32'hD1);
    rxin(8'hE0); rxin(8'hE1);
    rd(BASE);
    pulse_reset();
    rd(BASE);
    rd(BASE + 32'd4);

    // Decode holes
    rxin(8'h55);
    rd(BASE + 32'd12);
    rd(32'h0000_0004);
    wr(BASE + 32'd4, 32'hFF);
    wr(BASE + 32'd12, 32'hFF);
    rd(BASE);
    rd(BASE + 32'd4);
    rd(BASE + 32'd4);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      alist[0] = BASE; alist[1] = BASE + 32'd4; alist[2] = BASE + 32'd8;
      alist[3] = BASE + 32'd12; alist[4] = 32'h0000_0004; alist[5] = $urandom();
      r = $urandom();
      if (r[31:25] == 7'd0) pulse_reset();
      else cyc(r[0], r[1] & r[2], alist[$urandom_range(0, 5) % 6], $urandom(),
               r[3] & r[4], r[5] | r[6], 8'($urandom_range(0, 255)));
    end

    idle(DEPTH + 3, 1'b1);
    chk("tx_left", 32'(sb_tx.size()), 32'd0);
    chk("rd_left", 32'(sb_rd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
